// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode constants and instruction-format classification shared with the decoder
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILLEGAL
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:                                 f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  f = FMT_I;
      OP_STORE:                             f = FMT_S;
      OP_BRANCH:                            f = FMT_B;
      OP_LUI, OP_AUIPC:                     f = FMT_U;
      OP_JAL:                               f = FMT_J;
      default:                              f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous FIFO of {machine_code, address} with full/empty flags
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 44
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-bundle to machine-code encoder with addressed output FIFO
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int                DEPTH     = 2,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       machine_code,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
);

  fmt_e              fmt;
  logic [31:0]       code;
  logic              legal;
  logic              accept, push, pop;
  logic              full, empty;
  logic [ADDR_W-1:0] word_addr;

  logic              init_q, init_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  always_comb begin
    fmt   = fmt_of(opcode);
    legal = (fmt != FMT_ILLEGAL);
    case (fmt)
      FMT_R:   code = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   code = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   code = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   code = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   code = {imm[31:12], rd, opcode};
      FMT_J:   code = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: code = '0;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    // Legal when every bit above the field's sign bit replicates it.
    case (fmt)
      FMT_I, FMT_S: legal = (imm[31:11] == {21{imm[31]}});
      FMT_B:        legal = (imm[31:12] == {20{imm[31]}}) && !imm[0];
      FMT_J:        legal = (imm[31:20] == {12{imm[31]}}) && !imm[0];
      FMT_U:        legal = (imm[11:0] == 12'h000);
      default:      legal = legal;
    endcase
`endif
  end

  assign in_ready  = init_q && !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;
  assign word_addr = addr_clr ? BASE_ADDR : addr_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    init_d    = 1'b1;
    addr_d    = addr_q;
    err_d     = accept && !legal;
    err_cnt_d = err_cnt_q;
    if (push) begin
      addr_d = word_addr + ADDR_W'(4);
    end else if (addr_clr) begin
      addr_d = BASE_ADDR;
    end
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q    <= 1'b0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      init_q    <= init_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (32 + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({code, word_addr}),
    .pop   (pop),
    .rdata ({machine_code, out_addr}),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a behavioural model
module tb_instr_encoder;

  localparam int          ADDR_W = 12;
  localparam int unsigned BASE   = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        opcode = '0;
  logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic [31:0]       imm = '0;
  logic              addr_clr = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       machine_code;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [7:0]        err_cnt;

  always #5 clk = ~clk;

  instr_encoder #(
    .DEPTH     (2),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (12'(BASE))
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .funct3       (funct3),
    .funct7       (funct7),
    .imm          (imm),
    .addr_clr     (addr_clr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .machine_code (machine_code),
    .out_addr     (out_addr),
    .err          (err),
    .err_cnt      (err_cnt)
  );

  typedef struct packed {
    logic [31:0]       code;
    logic [ADDR_W-1:0] addr;
  } ent_t;

  ent_t        sb[$];
  int unsigned addr_m = BASE;
  int unsigned cnt_m  = 0;
  bit          last_acc;
  int          n_vec = 0;
  int          n_bad = 0;

  logic [6:0] legal_ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [6:0] op, input logic [31:0] im);
    int s;
    s = $signed(im);
    case (op)
      7'h33: return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
      7'h13, 7'h03, 7'h67, 7'h73, 7'h23: return (s >= -2048) && (s <= 2047);
      7'h63: return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      7'h6F: return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      7'h37, 7'h17: return (im % 4096) == 0;
`else
      7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] im);
    logic [31:0] o, rdv, a, b, f;
    o   = 32'(op);
    rdv = 32'(d) * 128;
    a   = 32'(s1) * 32768;
    b   = 32'(s2) * 1048576;
    f   = 32'(f3) * 4096;
    case (op)
      7'h33: return 32'(f7) * 33554432 + b + a + f + rdv + o;
      7'h13, 7'h03, 7'h67, 7'h73: return (im % 4096) * 1048576 + a + f + rdv + o;
      7'h23: return ((im / 32) % 128) * 33554432 + b + a + f + (im % 32) * 128 + o;
      7'h63: return ((im / 4096) % 2) * 32'h8000_0000 + ((im / 32) % 64) * 33554432 + b + a + f
                    + ((im / 2) % 16) * 256 + ((im / 2048) % 2) * 128 + o;
      7'h37, 7'h17: return (im / 4096) * 4096 + rdv + o;
      7'h6F: return ((im / 1048576) % 2) * 32'h8000_0000 + ((im / 2) % 1024) * 2097152
                    + ((im / 2048) % 2) * 1048576 + ((im / 4096) % 256) * 4096 + rdv + o;
      default: return 32'h0;
    endcase
  endfunction

  // One clock: called at posedge+1 with inputs set, returns at the next posedge+1.
  task automatic cycle();
    logic [6:0]  op, f7;
    logic [4:0]  d, s1, s2;
    logic [2:0]  f3;
    logic [31:0] im;
    bit          clr, acc, pop, err_exp;
    int unsigned wa;
    #3;
    op = opcode; d = rd; s1 = rs1; s2 = rs2; f3 = funct3; f7 = funct7; im = imm; clr = addr_clr;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    check_eq("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (pop && sb.size() != 0) begin
      check_eq("code", machine_code, sb[0].code);
      check_eq("addr", 32'(out_addr), 32'(sb[0].addr));
      sb.delete(0);
    end
    @(posedge clk);
    #1;
    err_exp = 1'b0;
    if (acc && ref_legal(op, im)) begin
      wa = clr ? BASE : addr_m;
      sb.push_back({ref_enc(op, d, s1, s2, f3, f7, im), 12'(wa)});
      addr_m = (wa + 4) % 4096;
    end else begin
      if (acc) begin
        err_exp = 1'b1;
        if (cnt_m < 255) cnt_m++;
      end
      if (clr) addr_m = BASE;
    end
    last_acc = acc;
    check_eq("err", 32'(err), 32'(err_exp));
    check_eq("err_cnt", 32'(err_cnt), 32'(cnt_m));
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    addr_clr  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) cycle();
    check_eq("drain_done", 32'(sb.size()), 32'h0);
  endtask

  task automatic send_check(input string tag, input logic [31:0] exp);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    check_eq(tag, machine_code, exp);
    drain();
  endtask

  task automatic clear_addr();
    in_valid = 1'b0;
    addr_clr = 1'b1;
    cycle();
    addr_clr = 1'b0;
  endtask

  initial begin
    #3;
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_code", machine_code, 32'h0);
    check_eq("rst_addr", 32'(out_addr), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("in_ready_after_rst", 32'(in_ready), 32'h1);

    // add x3,x1,x2
    set_fields(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    check_eq("add_code", machine_code, 32'h002081B3);
    check_eq("add_addr", 32'(out_addr), 32'h000);
    drain();
    clear_addr();

    // addi then sw back-to-back with out_ready held high
    out_ready = 1'b1;
    set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    cycle();
    check_eq("addi_code", machine_code, 32'h00500093);
    check_eq("addi_addr", 32'(out_addr), 32'h000);
    set_fields(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    cycle();
    check_eq("sw_code", machine_code, 32'h0020A423);
    check_eq("sw_addr", 32'(out_addr), 32'h004);
    drain();

    set_fields(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    send_check("beq_code", 32'h00208463);
    set_fields(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
    send_check("jal_code", 32'h010000EF);
    set_fields(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    send_check("lui_code", 32'h123452B7);

    // backpressure: two accepts fill the FIFO, the third bundle is held
    clear_addr();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    cycle();
    set_fields(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    cycle();
    check_eq("bp_in_ready", 32'(in_ready), 32'h0);
    set_fields(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    cycle();
    check_eq("bp_third_held", 32'(last_acc), 32'h0);
    out_ready = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 6 && !last_acc; i++) cycle();
    check_eq("bp_third_accept", 32'(last_acc), 32'h1);
    drain();

    // unknown opcode
    clear_addr();
    set_fields(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_eq("ill_err", 32'(err), 32'h1);
    check_eq("ill_err_cnt", 32'(err_cnt), 32'h1);
    check_eq("ill_out_valid", 32'(out_valid), 32'h0);
    cycle();
    check_eq("ill_err_drop", 32'(err), 32'h0);
    set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_eq("ill_next_addr", 32'(out_addr), 32'h000);
    drain();

    // out-of-range I immediate
    set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    check_eq("imm4096_err", 32'(err), 32'h1);
`else
    check_eq("imm4096_code", machine_code, 32'h00000093);
`endif
    drain();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      addr_clr  = ($urandom_range(0, 15) == 0);
      opcode    = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 9)];
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      case ($urandom_range(0, 2))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
      cycle();
    end
    drain();

    // error counter saturation
    set_fields(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    repeat (260) cycle();
    in_valid = 1'b0;
    cycle();
    check_eq("err_cnt_sat", 32'(err_cnt), 32'd255);

    // reset with two words buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_fields(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    cycle();
    cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
    sb.delete();
    addr_m = BASE;
    cnt_m  = 0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_eq("mid_rst_next_addr", 32'(out_addr), 32'(BASE));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs decoded RISC-V RV32I instruction fields back into 32-bit machine code; the inverse of the instruction decoder.
- Sits between the test/program-generation logic and instruction memory: accepts field bundles over a valid/ready handshake and buffers encoded words in a small FIFO.
- Emits each word with its target byte address, so a loader can stream a program into instruction memory.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- ADDR_W, 12, width of byte-address counter
- BASE_ADDR, 0, first byte address after reset or addr_clr (word-aligned)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- opcode  in  7  RV32I opcode
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3
- funct7  in  7
- imm  in  32  signed byte-offset/immediate value (U-type: full 32-bit value)
- addr_clr  in  1  sync reload of address counter to BASE_ADDR
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head
- machine_code  out  32  encoded word at FIFO head
- out_addr  out  ADDR_W  byte address for head word
- err  out  1  one-cycle pulse: last accepted bundle rejected
- err_cnt  out  8  saturating reject count

Behaviour:
- Reset (async, rst_n=0): FIFO empty, out_valid=0, machine_code=0, out_addr=0, err=0, err_cnt=0, addr counter=BASE_ADDR. in_ready=1 one cycle after release.
- Accept: in_valid && in_ready at edge N. The bundle is encoded combinationally and written to the FIFO at edge N. out_valid=1 from edge N (1-cycle latency) if the FIFO was empty.
- Pop: out_valid && out_ready at an edge. machine_code/out_addr show the head, registered from FIFO storage.
- in_ready = (count < DEPTH). Push and pop on the same edge are legal whenever not full. When full, in_ready=0 even if out_ready=1 (no pass-through).
- Formats by opcode:
  - R 0110011: funct7|rs2|rs1|funct3|rd|op.
  - I 0010011/0000011/1100111/1110011: imm[11:0]|rs1|funct3|rd|op.
  - S 0100011: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B 1100011: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U 0110111/0010111: imm[31:12]|rd|op.
  - J 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Unused fields for a format are ignored.
- Unknown opcode: bundle is accepted (handshake completes), not pushed, no address increment. err=1 for the cycle after the accept edge; err_cnt increments, saturating at 255.
- Address: each pushed word carries the current counter value; the counter then advances by 4, wrapping modulo 2^ADDR_W.
- addr_clr with a simultaneous push: the pushed word gets BASE_ADDR and the counter becomes BASE_ADDR+4.
- addr_clr alone: counter=BASE_ADDR. Already-buffered words are unaffected.
- Reset mid-stream discards all buffered words.

Optional Feature:
- IMM_RANGE_CHECK_EN defined: immediates outside the legal range are rejected exactly like an unknown opcode.
  - I/S: -2048..2047.
  - B: -4096..4094 with imm[0]=0.
  - J: -2^20..2^20-2 with imm[0]=0.
  - U: imm[11:0]=0.
- Not defined: no range checks; out-of-range bits are silently truncated per the format slicing.

Decomposition:
- Package riscv_pkg:
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
  - format enum FMT_R/I/S/B/U/J/ILLEGAL.
  - Shared with the decoder.
- One sub-module: instr_fifo, a synchronous FIFO of {machine_code, out_addr} with count, full/empty.

Test Plan:
- add x3,x1,x2 (op 0110011, rd=3, rs1=1, rs2=2, f3=0, f7=0) -> machine_code=0x002081B3, out_addr=0x000.
- addi x1,x0,5 then sw x2,8(x1) back-to-back, out_ready=1 -> 0x00500093 @0x000, then 0x0020A423 @0x004.
- beq x1,x2,+8 -> 0x00208463; jal x1,+16 -> 0x010000EF; lui x5 with imm=0x12345000 -> 0x123452B7.
- Backpressure:
  - out_ready=0, drive 3 bundles -> in_ready=0 after 2 accepts; third held.
  - Raise out_ready -> order preserved, addresses 0x000/0x004/0x008.
- Illegal opcode 0x7F -> err pulse 1 cycle, err_cnt=1, no out_valid, next legal word still gets 0x000.
- With IMM_RANGE_CHECK_EN, addi imm=4096 -> rejected (err=1).
- Without IMM_RANGE_CHECK_EN, addi imm=4096 -> 0x00000093.
- Assert rst_n with 2 words buffered -> out_valid=0 immediately, err_cnt=0, next word at BASE_ADDR.
